imm_gen_pipe: RTL and testbench

Registered, handshaked successor to the decode-stage combinational immediate generator. Takes one 32-bit RV instruction per cycle, classifies its format (R/I/S/B/U/J), builds the sign-extended immediate at a parametrised XLEN, and extracts shift amounts for shift-immediate instructions. Valid/ready on both sides, with a 2-entry skid buffer, so it sits between fetch and the decode/execute register without stalling throughput. Has a synchronous flush for branch redirect.

---
 rtl/imm_gen_pipe.sv | 103 ++++++++++
 tb/tb_imm_gen_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with valid/ready handshake and a 2-entry skid buffer.
// Format decode, sign-extension to XLEN and shift-amount extraction happen on the input side.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            is_shamt
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            sh;
  } ent_t;

  ent_t       dec, m_q, s_q;
  logic       m_vld, s_vld;
  logic       acc;
  logic [6:0] op;
  logic [2:0] f3;

  assign op = instr[6:0];
  assign f3 = instr[14:12];

  always_comb begin
    dec     = '0;
    dec.fmt = 3'd7;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: begin
        dec.fmt = 3'd1;
        dec.imm = XLEN'($signed(instr[31:20]));
        if ((op == 7'b0010011 || op == 7'b0011011) && (f3 == 3'b001 || f3 == 3'b101)) begin
          dec.sh  = 1'b1;
          // word shifts only ever use 5 shamt bits, even at XLEN=64
          dec.imm = (op == 7'b0011011) ? XLEN'(instr[24:20]) : XLEN'(instr[20 +: SHAMT_W]);
        end
      end
      7'b0100011: begin
        dec.fmt = 3'd2;
        dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = 3'd3;
        dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = 3'd4;
        dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = 3'd5;
        dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      7'b0110011, 7'b0111011: dec.fmt = 3'd0;
      default: ;
    endcase
  end

  // in_ready depends only on registered skid state, never on out_ready
  assign in_ready = ~s_vld;
  assign acc      = in_valid & ~s_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (m_vld && !out_ready) begin
      if (acc) begin
        s_q   <= dec;
        s_vld <= 1'b1;
      end
    end else if (s_vld) begin
      m_q   <= s_q;
      m_vld <= 1'b1;
      s_vld <= 1'b0;
    end else begin
      m_vld <= acc;
      if (acc) m_q <= dec;
    end
  end

  assign out_valid = m_vld;
  assign imm       = m_q.imm;
  assign fmt       = m_q.fmt;
  assign is_shamt  = m_q.sh;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus; a queue model
// tracks accepted instructions and an arithmetic decode model predicts every output.
module tb_imm_gen_pipe;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0;

  logic        ir32, ov32, sh32, ir64, ov64, sh64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  int nt = 0, nf = 0;
  logic [31:0] q[$];
  logic [31:0] dlog[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .instr(instr), .out_valid(ov32), .out_ready(out_ready), .imm(imm32), .fmt(fmt32),
    .is_shamt(sh32));

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .instr(instr), .out_valid(ov64), .out_ready(out_ready), .imm(imm64), .fmt(fmt64),
    .is_shamt(sh64));

  function automatic int m_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h1B: return 1;
      7'h23:                      return 2;
      7'h63:                      return 3;
      7'h37, 7'h17:               return 4;
      7'h6F:                      return 5;
      7'h33, 7'h3B:               return 0;
      default:                    return 7;
    endcase
  endfunction

  function automatic bit m_sh(input logic [31:0] i);
    return (i[6:0] == 7'h13 || i[6:0] == 7'h1B) && i[13:12] == 2'b01;
  endfunction

  // Field-gathering with 64-bit arithmetic, then truncation for the 32-bit view.
  function automatic logic [63:0] m_imm(input logic [31:0] i, input bit x64);
    longint sx, u, r;
    sx = longint'($signed(i));
    u  = longint'(i);
    r  = 0;
    if (m_sh(i))
      r = (u >> 20) & ((x64 && i[6:0] == 7'h13) ? 63 : 31);
    else
      case (m_fmt(i))
        1: r = sx >>> 20;
        2: r = ((sx >>> 25) << 5) | ((u >> 7) & 31);
        3: r = ((sx >>> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
               | (((u >> 8) & 15) << 1);
        4: r = (sx >>> 12) << 12;
        5: r = ((sx >>> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
               | (((u >> 21) & 1023) << 1);
        default: r = 0;
      endcase
    return x64 ? r : {32'b0, r[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nt++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard: acceptance/drain decided from the model's own occupancy.
  always @(posedge clk or negedge rst_n) begin : sb
    bit dr, ac;
    if (!rst_n) q.delete();
    else if (flush) q.delete();
    else begin
      dr = out_ready && q.size() > 0;
      ac = in_valid && q.size() < 2;
      if (dr) begin
        dlog.push_back(imm32);
        void'(q.pop_front());
      end
      if (ac) q.push_back(instr);
    end
  end

  always @(negedge clk) begin
    chk("ov32", ov32, q.size() > 0);
    chk("ov64", ov64, q.size() > 0);
    chk("ir32", ir32, q.size() < 2);
    chk("ir64", ir64, q.size() < 2);
    if (q.size() > 0) begin
      chk("imm32", imm32, m_imm(q[0], 1'b0));
      chk("imm64", imm64, m_imm(q[0], 1'b1));
      chk("fmt32", fmt32, m_fmt(q[0]));
      chk("fmt64", fmt64, m_fmt(q[0]));
      chk("sh32", sh32, m_sh(q[0]));
      chk("sh64", sh64, m_sh(q[0]));
    end
  end

  // Back-to-back send with out_ready=1; result must appear one edge later.
  task automatic send(input logic [31:0] x, input logic [63:0] e32, input logic [63:0] e64,
                      input int ef, input bit esh);
    in_valid = 1'b1;
    instr    = x;
    @(negedge clk);
    chk("lit_ov", ov32, 1);
    chk("lit_imm32", imm32, e32);
    chk("lit_imm64", imm64, e64);
    chk("lit_fmt32", fmt32, ef);
    chk("lit_fmt64", fmt64, ef);
    chk("lit_sh32", sh32, esh);
    chk("lit_sh64", sh64, esh);
    chk("model_pin32", m_imm(x, 1'b0), e32);
    chk("model_pin64", m_imm(x, 1'b1), e64);
  endtask

  task automatic push(input logic [31:0] x);
    int n;
    bit a;
    n = 0;
    in_valid = 1'b1;
    instr    = x;
    do begin
      a = ir32;
      @(negedge clk);
      n++;
    end while (!a && n < 50);
    if (!a) chk("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] iimm(input int v);
    return (32'(v) << 20) | 32'h13;
  endfunction

  initial begin
    #1;
    chk("rst_ov", ov32, 0);
    chk("rst_ir", ir32, 1);
    chk("rst_imm32", imm32, 0);
    chk("rst_imm64", imm64, 0);
    chk("rst_fmt", fmt32, 0);
    chk("rst_sh", sh32, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(32'h2FE00013, 64'h2FE, 64'h2FE, 1, 0);
    send(32'hFFE00013, 64'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1, 0);
    send(32'h2FA00003, 64'h2FA, 64'h2FA, 1, 0);
    send(32'h80000067, 64'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1, 0);
    send(32'h2E000F23, 64'h2FE, 64'h2FE, 2, 0);
    send(32'hFE000FE3, 64'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3, 0);
    send(32'h2FF0C06F, 64'hCAFE, 64'hCAFE, 5, 0);
    send(32'h40705013, 64'h7, 64'h7, 1, 1);
    send(32'hDEADB037, 64'hDEADB000, 64'hFFFFFFFFDEADB000, 4, 0);
    send(32'h02801013, 64'd8, 64'd40, 1, 1);
    send(32'h0280101B, 64'd8, 64'd8, 1, 1);
    send(32'hFFFFFFFF, 64'h0, 64'h0, 7, 0);
    send(32'h40B50533, 64'h0, 64'h0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);

    // backpressure: two accepts fill M and S, then in_ready drops
    out_ready = 1'b0;
    dlog.delete();
    push(iimm(1));
    push(iimm(2));
    in_valid = 1'b1;
    instr    = iimm(3);
    repeat (3) begin
      chk("bp_ir", ir32, 0);
      chk("bp_hold", imm32, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    push(iimm(3));
    push(iimm(4));
    repeat (3) @(negedge clk);
    chk("bp_count", dlog.size(), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++) chk("bp_order", dlog[i], i + 1);

    // flush with both entries full, offered entry discarded
    out_ready = 1'b0;
    push(iimm(5));
    push(iimm(6));
    in_valid = 1'b1;
    instr    = iimm(9);
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", ov32, 0);
    chk("fl_ir", ir32, 1);
    out_ready = 1'b1;
    dlog.delete();
    repeat (3) @(negedge clk);
    chk("fl_none", dlog.size(), 0);

    // flush while in_ready=1 still drops the offered entry
    out_ready = 1'b0;
    push(iimm(5));
    in_valid = 1'b1;
    instr    = iimm(9);
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_ov", ov32, 0);
    out_ready = 1'b1;
    dlog.delete();
    repeat (3) @(negedge clk);
    chk("fl2_none", dlog.size(), 0);

    // async reset between edges
    out_ready = 1'b0;
    push(iimm(5));
    push(32'hDEADB037);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_ov", ov32, 0);
    chk("ar_ov64", ov64, 0);
    chk("ar_ir", ir32, 1);
    chk("ar_imm32", imm32, 0);
    chk("ar_imm64", imm64, 0);
    chk("ar_fmt", fmt32, 0);
    chk("ar_sh", sh32, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'h2FE00013, 64'h2FE, 64'h2FE, 1, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
